mmcm_drp_ctrl: RTL and testbench

//  Reprograms the pixel-clock MMCM over its DRP port so the display pipeline can switch

---
 rtl/mmcm_drp_pkg.sv | 32 +++
 rtl/mmcm_cfg_rom.sv | 32 +++
 rtl/mmcm_drp_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mmcm_drp_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the pixel-clock MMCM DRP reprogramming controller.
package mmcm_drp_pkg;

  localparam int NUM_MODES = 4;
  localparam int NUM_REGS  = 10;
  localparam int MODE_W    = $clog2(NUM_MODES);
  localparam int IDX_W     = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ASSERT_RST,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_NEXT,
    S_RELEASE,
    S_LOCK_WAIT
  } state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  // A set mask bit preserves the bit read back from the MMCM.
  function automatic logic [15:0] rmwMerge(input logic [15:0] readData, input drp_entry_t entry);
    return (readData & entry.mask) | entry.data;
  endfunction

endpackage

// File: rtl/mmcm_cfg_rom.sv
// Per-mode MMCM register table: (mode, index) -> DRP address, keep-mask and new field data.
module mmcm_cfg_rom
  import mmcm_drp_pkg::*;
(
  input  logic [MODE_W-1:0] mode_i,
  input  logic [IDX_W-1:0]  index_i,
  output drp_entry_t        entry_o
);

  logic [NUM_MODES-1:0][15:0] dataRow;

  // Each row lists field data as {mode3, mode2, mode1, mode0}.
  always_comb begin
    entry_o = '0;
    dataRow = '0;
    case (index_i)
      4'd0: begin entry_o.addr = 7'h28; entry_o.mask = 16'h0000; dataRow = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; end
      4'd1: begin entry_o.addr = 7'h08; entry_o.mask = 16'h1000; dataRow = {16'h0145, 16'h0104, 16'h0186, 16'h0A28}; end
      4'd2: begin entry_o.addr = 7'h09; entry_o.mask = 16'hFC00; dataRow = {16'h0000, 16'h0040, 16'h0000, 16'h0080}; end
      4'd3: begin entry_o.addr = 7'h14; entry_o.mask = 16'h1000; dataRow = {16'h0618, 16'h0410, 16'h0514, 16'h0596}; end
      4'd4: begin entry_o.addr = 7'h15; entry_o.mask = 16'hFC00; dataRow = {16'h0080, 16'h0000, 16'h0000, 16'h0080}; end
      4'd5: begin entry_o.addr = 7'h16; entry_o.mask = 16'hC000; dataRow = {16'h0083, 16'h1041, 16'h1041, 16'h1041}; end
      4'd6: begin entry_o.addr = 7'h18; entry_o.mask = 16'hFC00; dataRow = {16'h00FA, 16'h0271, 16'h01E8, 16'h00FA}; end
      4'd7: begin entry_o.addr = 7'h19; entry_o.mask = 16'h8000; dataRow = {16'h7C01, 16'h7C01, 16'h7C01, 16'h7C01}; end
      4'd8: begin entry_o.addr = 7'h1A; entry_o.mask = 16'h8000; dataRow = {16'h7DE9, 16'h7FE9, 16'h7DE9, 16'h0145}; end
      4'd9: begin entry_o.addr = 7'h4E; entry_o.mask = 16'h66FF; dataRow = {16'h9100, 16'h0900, 16'h1900, 16'h9900}; end
      default: begin entry_o.addr = 7'h00; entry_o.mask = 16'hFFFF; dataRow = '0; end
    endcase
    entry_o.data = dataRow[mode_i];
  end

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// Pixel-clock MMCM reprogrammer: holds the MMCM in reset, read-modify-writes every table
// register over DRP, releases reset and waits for a synchronised LOCKED.
module mmcm_drp_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int DEFAULT_MODE = 0,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        sysclk_i,
  input  logic        rst_ni,
  input  logic [1:0]  mode_sel_i,
  input  logic        mode_req_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  cur_mode_o,
  output logic [6:0]  daddr_o,
  output logic [15:0] di_o,
  output logic        den_o,
  output logic        dwe_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  input  logic        locked_i,
  output logic        mmcm_rst_o
);

  localparam int DRP_CW  = $clog2(DRP_TIMEOUT);
  localparam int LOCK_CW = $clog2(LOCK_TIMEOUT);
  localparam logic [DRP_CW-1:0]  DRP_LAST  = DRP_CW'(DRP_TIMEOUT - 1);
  localparam logic [LOCK_CW-1:0] LOCK_LAST = LOCK_CW'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [15:0]         di_q, di_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [MODE_W-1:0]   curMode_q, curMode_d;
  logic                mmcmRst_q, mmcmRst_d;
  logic [DRP_CW-1:0]   drpCnt_q, drpCnt_d;
  logic [LOCK_CW-1:0]  lockCnt_q, lockCnt_d;
  logic [1:0]          lockSync_q;
  drp_entry_t          romEntry;

  mmcm_cfg_rom u_rom (
    .mode_i  (mode_q),
    .index_i (index_q),
    .entry_o (romEntry)
  );

  // Reset lands in ASSERT_RST with the default mode latched, which is the boot load.
  always_ff @(posedge sysclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_ASSERT_RST;
      mode_q     <= MODE_W'(DEFAULT_MODE);
      index_q    <= '0;
      di_q       <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      curMode_q  <= '0;
      mmcmRst_q  <= 1'b1;
      drpCnt_q   <= '0;
      lockCnt_q  <= '0;
      lockSync_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      index_q    <= index_d;
      di_q       <= di_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      curMode_q  <= curMode_d;
      mmcmRst_q  <= mmcmRst_d;
      drpCnt_q   <= drpCnt_d;
      lockCnt_q  <= lockCnt_d;
      lockSync_q <= {lockSync_q[0], locked_i};
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    index_d   = index_q;
    di_d      = di_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    curMode_d = curMode_q;
    mmcmRst_d = mmcmRst_q;
    drpCnt_d  = drpCnt_q;
    lockCnt_d = lockCnt_q;

    case (state_q)
      S_IDLE: begin
        if (mode_req_i) begin
          mode_d    = mode_sel_i;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          mmcmRst_d = 1'b1;
          state_d   = S_ASSERT_RST;
        end
      end
      S_ASSERT_RST: begin
        mmcmRst_d = 1'b1;
        index_d   = '0;
        state_d   = S_RD;
      end
      S_RD: begin
        drpCnt_d = '0;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drdy_i) begin
          di_d    = rmwMerge(do_i, romEntry);
          state_d = S_WR;
        end else if (drpCnt_q == DRP_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          drpCnt_d = drpCnt_q + 1'b1;
        end
      end
      S_WR: begin
        drpCnt_d = '0;
        state_d  = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (drdy_i) begin
          state_d = S_NEXT;
        end else if (drpCnt_q == DRP_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          drpCnt_d = drpCnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (index_q == LAST_IDX) begin
          mmcmRst_d = 1'b0;
          state_d   = S_RELEASE;
        end else begin
          index_d = index_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_RELEASE: begin
        lockCnt_d = '0;
        state_d   = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (lockSync_q[1]) begin
          curMode_d = mode_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (lockCnt_q == LOCK_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          lockCnt_d = lockCnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign den_o      = (state_q == S_RD) || (state_q == S_WR);
  assign dwe_o      = (state_q == S_WR);
  assign daddr_o    = den_o ? romEntry.addr : 7'h00;
  assign di_o       = di_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign cur_mode_o = curMode_q;
  assign mmcm_rst_o = mmcmRst_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Bench for mmcm_drp_ctrl: a behavioural DRP register file and MMCM lock model drive the DUT,
// and every DRP access is compared with a table-driven read-modify-write reference.
module tb_mmcm_drp_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [1:0]  modeSel = 2'd0;
  logic        modeReq = 1'b0;
  logic [15:0] doData;
  logic        drdy;
  logic        locked;
  logic        busy, done, err, den, dwe, mmcmRst;
  logic [1:0]  curMode;
  logic [6:0]  daddr;
  logic [15:0] di;

  int total = 0;
  int bad = 0;
  int drpDelay = 3;
  int lockDelay = 100;
  bit lockNever = 1'b0;
  bit withholdEn = 1'b0;
  int withholdIdx = 3;
  int rdCount = 0;

  logic [15:0] drpMem [128];
  logic [15:0] shadow [128];
  logic [23:0] accQ [$];
  logic [23:0] expQ [$];

  // Reference register table, one row per register index, columns are modes 0..3.
  logic [6:0]  romAddr [10] = '{7'h28, 7'h08, 7'h09, 7'h14, 7'h15, 7'h16, 7'h18, 7'h19, 7'h1A, 7'h4E};
  logic [15:0] romMask [10] = '{16'h0000, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00,
                                16'hC000, 16'hFC00, 16'h8000, 16'h8000, 16'h66FF};
  logic [15:0] romData [4][10] = '{
    '{16'hFFFF, 16'h0A28, 16'h0080, 16'h0596, 16'h0080, 16'h1041, 16'h00FA, 16'h7C01, 16'h0145, 16'h9900},
    '{16'hFFFF, 16'h0186, 16'h0000, 16'h0514, 16'h0000, 16'h1041, 16'h01E8, 16'h7C01, 16'h7DE9, 16'h1900},
    '{16'hFFFF, 16'h0104, 16'h0040, 16'h0410, 16'h0000, 16'h1041, 16'h0271, 16'h7C01, 16'h7FE9, 16'h0900},
    '{16'hFFFF, 16'h0145, 16'h0000, 16'h0618, 16'h0080, 16'h0083, 16'h00FA, 16'h7C01, 16'h7DE9, 16'h9100}};

  mmcm_drp_ctrl dut (
    .sysclk_i   (clk),
    .rst_ni     (rstN),
    .mode_sel_i (modeSel),
    .mode_req_i (modeReq),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .cur_mode_o (curMode),
    .daddr_o    (daddr),
    .di_o       (di),
    .den_o      (den),
    .dwe_o      (dwe),
    .do_i       (doData),
    .drdy_i     (drdy),
    .locked_i   (locked),
    .mmcm_rst_o (mmcmRst)
  );

  always #5 clk = ~clk;

  // DRP slave: logs each access, answers drpDelay cycles after DEN unless the read is withheld.
  initial begin : drpResponder
    bit justTicked;
    bit isRead;
    bit hold;
    bit aborted;
    logic [6:0] a;
    drdy = 1'b0;
    doData = 16'h0;
    justTicked = 1'b0;
    forever begin
      if (!justTicked) begin
        @(posedge clk);
        #1;
      end
      justTicked = 1'b0;
      if (rstN && den) begin
        isRead = !dwe;
        a = daddr;
        accQ.push_back({dwe, daddr, (dwe ? di : 16'h0)});
        if (!isRead) drpMem[a] = di;
        hold = isRead && withholdEn && (rdCount == withholdIdx);
        if (isRead) rdCount++;
        aborted = 1'b0;
        for (int i = 0; i < drpDelay; i++) begin
          @(posedge clk);
          #1;
          if (!rstN) aborted = 1'b1;
        end
        if (!aborted && !hold && rstN) begin
          drdy = 1'b1;
          doData = isRead ? drpMem[a] : 16'($urandom);
          @(posedge clk);
          #1;
          drdy = 1'b0;
          justTicked = 1'b1;
        end
      end
    end
  end

  // MMCM lock model: LOCKED rises lockDelay cycles after MMCM_RST falls.
  initial begin : lockModel
    int lkCnt;
    locked = 1'b0;
    lkCnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstN || mmcmRst || lockNever) begin
        locked = 1'b0;
        lkCnt = 0;
      end else if (lkCnt >= lockDelay) begin
        locked = 1'b1;
      end else begin
        lkCnt++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode);
    modeSel = mode;
    modeReq = 1'b1;
    tick();
    modeReq = 1'b0;
  endtask

  task automatic startRequest(input logic [1:0] mode);
    accQ.delete();
    rdCount = 0;
    buildExpected(mode);
    applyStimulus(mode);
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_mmcm_rst"}, 32'(mmcmRst), 32'd1);
    checkOutput({pfx, "_busy"}, 32'(busy), 32'd1);
    checkOutput({pfx, "_done"}, 32'(done), 32'd0);
    checkOutput({pfx, "_err"}, 32'(err), 32'd0);
    checkOutput({pfx, "_cur_mode"}, 32'(curMode), 32'd0);
    checkOutput({pfx, "_daddr"}, 32'(daddr), 32'd0);
    checkOutput({pfx, "_di"}, 32'(di), 32'd0);
    checkOutput({pfx, "_den"}, 32'(den), 32'd0);
    checkOutput({pfx, "_dwe"}, 32'(dwe), 32'd0);
  endtask

  // Expected access list: per register a read, then a write of (old & mask) | data.
  task automatic buildExpected(input logic [1:0] mode);
    logic [15:0] tmp [128];
    logic [15:0] w;
    logic [6:0] a;
    tmp = shadow;
    expQ.delete();
    for (int r = 0; r < 10; r++) begin
      a = romAddr[r];
      expQ.push_back({1'b0, a, 16'h0});
      w = (tmp[a] & romMask[r]) | romData[mode][r];
      tmp[a] = w;
      expQ.push_back({1'b1, a, w});
    end
  endtask

  task automatic commitWrites(input int n);
    for (int i = 0; i < n && i < expQ.size(); i++)
      if (expQ[i][23]) shadow[expQ[i][22:16]] = expQ[i][15:0];
  endtask

  task automatic compareAccesses(input string tag, input int n);
    checkOutput({tag, "_count"}, 32'(accQ.size()), 32'(n));
    for (int i = 0; i < n && i < accQ.size(); i++)
      checkOutput($sformatf("%s_acc%0d", tag, i), 32'(accQ[i]), 32'(expQ[i]));
  endtask

  task automatic waitEnd(input int bound, output int cycles, output int dones);
    cycles = 0;
    dones = 0;
    while (cycles < bound) begin
      tick();
      cycles++;
      if (done) dones++;
      if (done || err) break;
    end
    checkOutput("sequence_ended_in_bound", 32'(done | err), 32'd1);
  endtask

  task automatic runAndCheck(input string tag, input logic [1:0] mode);
    int cyc;
    int dones;
    waitEnd(5000, cyc, dones);
    checkOutput({tag, "_done_pulses"}, 32'(dones), 32'd1);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_cur_mode"}, 32'(curMode), 32'(mode));
    checkOutput({tag, "_mmcm_rst"}, 32'(mmcmRst), 32'd0);
    compareAccesses(tag, 20);
    commitWrites(20);
    tick();
    checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin : stimulus
    int cyc;
    int dones;
    int readsSeen;
    int writesSeen;
    int denCyc;
    int errCyc;
    int relCyc;
    logic [1:0] m;
    logic [1:0] prevCur;

    for (int i = 0; i < 128; i++) begin
      shadow[i] = 16'($urandom);
      drpMem[i] = shadow[i];
    end
    shadow[7'h1A] = 16'hABCD;
    drpMem[7'h1A] = 16'hABCD;

    $display("[TB] reset values");
    tick();
    tick();
    checkResetValues("reset");

    $display("[TB] boot load of default mode");
    accQ.delete();
    rdCount = 0;
    buildExpected(2'd0);
    rstN = 1'b1;
    runAndCheck("boot", 2'd0);
    checkOutput("boot_rmw_di_8145", 32'(accQ[17][15:0]), 32'h8145);

    $display("[TB] minimum latency");
    drpDelay = 1;
    lockDelay = 0;
    m = 2'($urandom_range(3, 0));
    startRequest(m);
    waitEnd(500, cyc, dones);
    // Request cycle and the first waitEnd sample are two cycles apart.
    checkOutput("min_latency", 32'(cyc + 2), 32'(2 + 5 * 10 + 1 + 3));
    checkOutput("min_latency_cur_mode", 32'(curMode), 32'(m));
    commitWrites(20);
    tick();

    $display("[TB] random mode requests");
    for (int k = 0; k < 4; k++) begin
      m = 2'($urandom_range(3, 0));
      drpDelay = $urandom_range(4, 1);
      lockDelay = $urandom_range(20, 0);
      startRequest(m);
      runAndCheck($sformatf("rand%0d", k), m);
    end

    $display("[TB] request while busy is ignored");
    drpDelay = 2;
    lockDelay = 10;
    startRequest(2'd2);
    repeat (5) tick();
    checkOutput("busy_during_seq", 32'(busy), 32'd1);
    applyStimulus(2'd1);
    runAndCheck("ignored_req", 2'd2);

    $display("[TB] DRP timeout on fourth read");
    prevCur = curMode;
    m = 2'($urandom_range(3, 0));
    withholdEn = 1'b1;
    withholdIdx = 3;
    startRequest(m);
    readsSeen = 0;
    denCyc = -1;
    errCyc = -1;
    dones = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (den && !dwe) begin
        readsSeen++;
        if (readsSeen == 4) denCyc = c;
      end
      if (done) dones++;
      if (err) begin
        errCyc = c;
        break;
      end
      if (done) break;
    end
    checkOutput("drp_to_err", 32'(err), 32'd1);
    checkOutput("drp_to_latency", 32'(errCyc - denCyc), 32'd65);
    checkOutput("drp_to_no_done", 32'(dones), 32'd0);
    checkOutput("drp_to_busy", 32'(busy), 32'd0);
    checkOutput("drp_to_mmcm_rst", 32'(mmcmRst), 32'd1);
    checkOutput("drp_to_cur_mode", 32'(curMode), 32'(prevCur));
    compareAccesses("drp_to", 7);
    commitWrites(7);
    withholdEn = 1'b0;
    repeat (3) tick();
    checkOutput("drp_to_err_sticky", 32'(err), 32'd1);

    $display("[TB] next request clears error");
    m = 2'($urandom_range(3, 0));
    startRequest(m);
    checkOutput("err_cleared", 32'(err), 32'd0);
    checkOutput("err_cleared_busy", 32'(busy), 32'd1);
    runAndCheck("after_err", m);

    $display("[TB] lock timeout");
    prevCur = curMode;
    lockNever = 1'b1;
    drpDelay = 1;
    m = 2'($urandom_range(3, 0));
    startRequest(m);
    relCyc = -1;
    errCyc = -1;
    dones = 0;
    for (int c = 0; c < 70000; c++) begin
      tick();
      if (relCyc < 0 && !mmcmRst) relCyc = c;
      if (done) dones++;
      if (err) begin
        errCyc = c;
        break;
      end
      if (done) break;
    end
    checkOutput("lock_to_err", 32'(err), 32'd1);
    checkOutput("lock_to_latency", 32'(errCyc - relCyc), 32'd65536);
    checkOutput("lock_to_no_done", 32'(dones), 32'd0);
    checkOutput("lock_to_mmcm_rst", 32'(mmcmRst), 32'd0);
    checkOutput("lock_to_busy", 32'(busy), 32'd0);
    checkOutput("lock_to_cur_mode", 32'(curMode), 32'(prevCur));
    compareAccesses("lock_to", 20);
    commitWrites(20);
    lockNever = 1'b0;
    lockDelay = 100;

    $display("[TB] reset during write wait");
    drpDelay = 3;
    m = 2'($urandom_range(3, 0));
    startRequest(m);
    writesSeen = 0;
    for (int c = 0; c < 1000 && writesSeen < 3; c++) begin
      tick();
      if (den && dwe) writesSeen++;
    end
    checkOutput("rst_mid_third_write_seen", 32'(writesSeen), 32'd3);
    tick();
    #2;
    rstN = 1'b0;
    #1;
    checkResetValues("rst_mid");
    compareAccesses("rst_mid_partial", 6);
    commitWrites(6);
    repeat (3) tick();
    accQ.delete();
    rdCount = 0;
    buildExpected(2'd0);
    rstN = 1'b1;
    runAndCheck("reload", 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
